serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor. It computes Diff_out = A - B, one bit per clock, LSB first, using a single full-subtractor cell with a registered borrow.
- It is the subtraction counterpart of the combinational ripple adder. It trades area for latency and is used where A - B and a borrow flag are needed at low gate cost.
- A start/busy/done handshake lets a controller launch an operation and collect the result.

---
 rtl/serial_subtractor_if.sv | 20 ++
 rtl/serial_subtractor.sv | 88 ++++++++
 tb/tb_serial_subtractor.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Interface for the bit-serial subtractor: the controller side launches work with
// start/A/B and collects busy/done/Diff_out.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  // Handshake: the subtractor accepts start (and captures A/B) only while idle,
  // on the rising edge where start is high. busy stays high for exactly WIDTH
  // cycles after that. done pulses for one cycle with Diff_out already updated.
  // Any start seen while busy or done is high is dropped, not queued.
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   Diff_out;
  logic [1:0]       dbg_state;

  modport master (output start, A, B, input busy, done, Diff_out, dbg_state);
  modport slave  (input start, A, B, output busy, done, Diff_out, dbg_state);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell with a registered borrow,
// LSB first, producing Diff_out = {A < B, A - B} WIDTH+1 cycles after start.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   diff_out;

  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic borrow_nxt;
  logic last;

  always_comb begin
    a_bit      = shift_a[0];
    b_bit      = shift_b[0];
    d_bit      = a_bit ^ b_bit ^ borrow;
    borrow_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
    last       = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The minuend register doubles as the difference register: each consumed
  // minuend bit frees its slot at the top, where the new difference bit lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shift_a  <= '0;
      shift_b  <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      diff_out <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_a <= bus.A;
            shift_b <= bus.B;
            borrow  <= 1'b0;
            cnt     <= '0;
          end
        end
        RUN: begin
          shift_a <= {d_bit, shift_a[WIDTH-1:1]};
          shift_b <= shift_b >> 1;
          borrow  <= borrow_nxt;
          cnt     <= cnt + CW'(1);
          // Result is published on entry to DONE so it is valid alongside done.
          if (last) diff_out <= {borrow_nxt, d_bit, shift_a[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.Diff_out  = diff_out;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=2 instances, vector
// table, handshake/reset corner sequences and a randomized run against an arithmetic model.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(2)) if2 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));
  serial_subtractor #(.WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  int tests  = 0;
  int failed = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] model8(input int a, input int b);
    int d = a - b;
    if (d < 0) return 9'(d + 256) | 9'h100;
    return 9'(d);
  endfunction

  function automatic logic [2:0] model2(input int a, input int b);
    int d = a - b;
    if (d < 0) return 3'(d + 4) | 3'b100;
    return 3'(d);
  endfunction

  // One WIDTH=8 operation; the expected result is taken from the scoreboard queue.
  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] exp;
    logic [8:0] prev;
    int cyc;
    int busy_n;
    bit stable;
    exp = exp_q.pop_front();
    @(negedge clk);
    if8.A = a; if8.B = b; if8.start = 1'b1;
    prev = if8.Diff_out;
    @(negedge clk);
    if8.start = 1'b0; if8.A = 8'($urandom); if8.B = 8'($urandom);
    cyc = 0; busy_n = 0; stable = 1'b1;
    while (!if8.done && cyc < 40) begin
      if (if8.busy) busy_n++;
      if (if8.Diff_out !== prev) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("w8 done seen", 32'(if8.done), 32'd1);
    chk("w8 latency", 32'(cyc + 1), 32'd9);
    chk("w8 busy cycles", 32'(busy_n), 32'd8);
    chk("w8 diff stable", 32'(stable), 32'd1);
    chk("w8 result", 32'(if8.Diff_out), 32'(exp));
    @(negedge clk);
    chk("w8 done one cycle", 32'(if8.done), 32'd0);
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic [2:0] exp);
    int cyc;
    @(negedge clk);
    if2.A = a; if2.B = b; if2.start = 1'b1;
    @(negedge clk);
    if2.start = 1'b0; if2.A = 2'($urandom); if2.B = 2'($urandom);
    cyc = 0;
    while (!if2.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("w2 done seen", 32'(if2.done), 32'd1);
    chk("w2 latency", 32'(cyc + 1), 32'd3);
    chk("w2 result", 32'(if2.Diff_out), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    vec_t vecs[5];
    int dcount;
    int last_i;
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0] = '{8'h5A, 8'h3C, 9'h01E};
    vecs[1] = '{8'h00, 8'h01, 9'h1FF};
    vecs[2] = '{8'h3C, 8'h5A, 9'h1E2};
    vecs[3] = '{8'hFF, 8'h00, 9'h0FF};
    vecs[4] = '{8'h80, 8'h80, 9'h000};

    // Clock/reset
    reset = 1'b1;
    if8.start = 1'b0; if8.A = '0; if8.B = '0;
    if2.start = 1'b0; if2.A = '0; if2.B = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(if8.busy), 32'd0);
    chk("reset done", 32'(if8.done), 32'd0);
    chk("reset diff", 32'(if8.Diff_out), 32'd0);
    chk("reset w2 diff", 32'(if2.Diff_out), 32'd0);
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].exp);
      op8(vecs[i].a, vecs[i].b);
    end

    // start held high: back-to-back operations every 10 cycles
    @(negedge clk);
    if8.A = 8'h10; if8.B = 8'h01; if8.start = 1'b1;
    dcount = 0; last_i = -1;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (if8.done) begin
        chk("hold value", 32'(if8.Diff_out), 32'h00F);
        if (last_i >= 0) chk("hold period", 32'(i - last_i), 32'd10);
        last_i = i;
        dcount++;
      end
    end
    if8.start = 1'b0;
    chk("hold done count", 32'(dcount), 32'd3);
    repeat (12) @(negedge clk);

    // Operands and start disturbed while running
    @(negedge clk);
    if8.A = 8'h20; if8.B = 8'h05; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      if (i < 8) begin
        if8.A = 8'($urandom); if8.B = 8'($urandom); if8.start = i[0];
      end else begin
        if8.start = 1'b0;
      end
      if (if8.done) begin
        dcount++;
        chk("midrun value", 32'(if8.Diff_out), 32'h01B);
      end
      @(negedge clk);
    end
    chk("midrun done count", 32'(dcount), 32'd1);

    // Reset on the fourth RUN cycle
    @(negedge clk);
    if8.A = 8'hAA; if8.B = 8'h55; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset busy", 32'(if8.busy), 32'd0);
    chk("midreset done", 32'(if8.done), 32'd0);
    chk("midreset diff", 32'(if8.Diff_out), 32'd0);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if8.done) dcount++;
    end
    chk("midreset no done", 32'(dcount), 32'd0);
    exp_q.push_back(9'h006);
    op8(8'h09, 8'h03);

    // WIDTH=2 exhaustive
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        op2(2'(a), 2'(b), model2(a, b));

    // Randomized against the arithmetic model
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(model8(int'(ra), int'(rb)));
      op8(ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
